apb_rr_master: RTL and testbench
================================

# apb_rr_master

Round-robin APB master that shares a single APB requester port among NUM_REQ internal clients. Each client presents a single read or write command. The block arbitrates among them and runs the APB SETUP/ACCESS sequence, honouring Pready wait states. It returns read data and error status to the originating client, and ends hung accesses with a timeout error. It sits between the system-side clients and the APB bus that the slave monitor and driver connect to.

## Interface
- NUM_REQ, 4: number of requesters, 2..8
- ADDR_W, 32: APB address width
- DATA_W, 32: APB data width
- TIMEOUT, 16: maximum ACCESS cycles without Pready before forced error, ≥2
- Pclk  in  1  APB clock; all logic is on its rising edge
- Preset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  per-client command pending
- req_write  in  NUM_REQ  per-client direction (1 = write)
- req_addr  in  NUM_REQ*ADDR_W  per-client address; client i uses slice [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  per-client write data
- req_ready  out  NUM_REQ  one-hot grant; the command is accepted on a cycle with valid & ready
- rsp_valid  out  NUM_REQ  one-hot one-cycle completion pulse
- rsp_rdata  out  DATA_W  read data, valid with rsp_valid; 0 for writes
- rsp_slverr  out  1  error flag, valid with rsp_valid
- Psel, Penable, Pwrite  out  1  APB control
- Paddr  out  ADDR_W  APB address
- Pwdata  out  DATA_W  APB write data
- Prdata  in  DATA_W  APB read data
- Pready, Pslverr  in  1  APB completion and error

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- Grant window: state IDLE, or state ACCESS with a completion this cycle (Pready=1 or timeout).
  - In a grant window with any req_valid, the arbiter asserts exactly one req_ready, combinationally.
  - The command is registered and the next state is SETUP.
  - With no request, the next state is IDLE.
- Round-robin arbitration:
  - Search starts at pointer ptr and wraps modulo NUM_REQ.
  - On a grant to client g, ptr becomes (g+1) mod NUM_REQ.
  - ptr resets to 0.
- SETUP: Psel=1, Penable=0, Paddr/Pwrite/Pwdata hold the registered command. The next state is always ACCESS.
- ACCESS: Psel=1, Penable=1, with Paddr/Pwrite/Pwdata unchanged. Pready and Pslverr are sampled every cycle.
- Completion on Pready=1:
  - rsp_valid[g] pulses in the next cycle.
  - rsp_rdata = Prdata for a read, 0 for a write.
  - rsp_slverr = Pslverr.
- Timeout:
  - wait_cnt counts ACCESS cycles, with the first cycle counted as 1.
  - If wait_cnt reaches TIMEOUT with Pready=0, the access completes as if Pready=1, but with rsp_slverr=1 and rsp_rdata=0.
  - Pready=1 in that same cycle wins: normal completion, no timeout.
- Leaving ACCESS with no new grant returns to IDLE, where Psel=0 and Penable=0. Paddr, Pwrite and Pwdata keep their last values.
- Reset: Preset low forces every output to 0, state to IDLE, ptr to 0 and wait_cnt to 0, immediately.
  - req_ready is gated to 0 while Preset is low.
  - An in-flight access is abandoned and produces no rsp_valid.

## Timing
- Reset values: Psel, Penable, Pwrite, Paddr, Pwdata, req_ready, rsp_valid, rsp_rdata and rsp_slverr are all 0.
- Latency from IDLE: grant at cycle 0, SETUP at cycle 1, ACCESS at cycle 2. With Pready=1 at cycle 2, rsp_valid is high in cycle 3.
- Back-to-back throughput: 2 cycles per zero-wait transfer. The next SETUP immediately follows the completing ACCESS, and Psel never drops.
- Each wait state adds 1 cycle. The worst case is TIMEOUT ACCESS cycles.
- rsp_valid for a transfer coincides with the SETUP cycle of the next granted transfer.
- Clients must hold req_* stable while req_valid=1 and req_ready=0.
- The controller ignores req_* of clients that are not granted.

## Structure
- Package apb_ctrl_pkg contains:
  - state_e enum (IDLE, SETUP, ACCESS);
  - default width constants (ADDR_W, DATA_W);
  - TIMEOUT default.
- Sub-module apb_rr_arbiter: parameterised NUM_REQ rotating-priority arbiter.
  - Inputs: req vector, enable (grant window).
  - Outputs: one-hot grant and encoded index.
  - Owns the ptr register.
- Top level holds the FSM, the command register, wait_cnt and the response register.

## Test plan
- Reset mid-access:
  - Stimulus: assert Preset low while in ACCESS with Pready held 0.
  - Required: all outputs read 0 within the same cycle; no rsp_valid after release; the first grant after reset goes to client 0.
- Single zero-wait read:
  - Stimulus: client 2 reads addr 0x0000_0010, with Prdata=0xDEAD_BEEF and Pready=1 in the first ACCESS cycle.
  - Required: SETUP then ACCESS, Paddr=0x10, Pwrite=0; rsp_valid=4'b0100 one cycle later with rsp_rdata=0xDEAD_BEEF and rsp_slverr=0.
- Write with 3 wait states:
  - Stimulus: client 0 writes 0x1234_5678 to 0x20.
  - Required: Penable high for 4 cycles; Pwdata stable throughout; rsp_rdata=0.
- Round-robin fairness:
  - Stimulus: all 4 clients hold req_valid=1 with zero-wait slaves.
  - Required: grants in order 0,1,2,3,0; Psel continuously high; one transfer every 2 cycles.
- Timeout with TIMEOUT=16:
  - Stimulus: Pready held 0.
  - Required: the access ends after 16 ACCESS cycles with rsp_slverr=1 and rsp_rdata=0, then IDLE.
  - Repeat with Pready=1 in ACCESS cycle 16: normal completion with rsp_slverr=0.
- Slave error:
  - Stimulus: Pready=1 and Pslverr=1 on a read by client 3.
  - Required: rsp_valid=4'b1000 with rsp_slverr=1; ptr advances to 0.

Source files
------------

// File: rtl/apb_rr_master_pkg.sv
// Shared types and default sizing for the round-robin APB master.
package apb_ctrl_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

endpackage

// File: rtl/apb_rr_master_if.sv
// APB requester bus between the round-robin master and the slave side.
interface apb_rr_master_if
  import apb_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              Psel;
  logic              Penable;
  logic              Pwrite;
  logic [ADDR_W-1:0] Paddr;
  logic [DATA_W-1:0] Pwdata;
  logic [DATA_W-1:0] Prdata;
  logic              Pready;
  logic              Pslverr;

  modport master (
    output Psel, Penable, Pwrite, Paddr, Pwdata,
    input  Prdata, Pready, Pslverr
  );

  modport slave (
    input  Psel, Penable, Pwrite, Paddr, Pwdata,
    output Prdata, Pready, Pslverr
  );

endinterface

// File: rtl/apb_rr_master_arbiter.sv
// Rotating-priority arbiter: searches from ptr upward, wrapping, and moves
// ptr just past the winner whenever a grant is issued.
module apb_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req,
  input  logic                       enable,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] ptr;
  logic             found;

  function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int offset);
    int s;
    s = int'(base) + offset;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDX_W'(s);
  endfunction

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[wrap_idx(ptr, i)]) begin
        found                   = 1'b1;
        grant_idx               = wrap_idx(ptr, i);
        grant[wrap_idx(ptr, i)] = 1'b1;
      end
    end
    if (!enable) begin
      grant = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (enable && found) begin
      ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_rr_master.sv
// Round-robin APB master: arbitrates NUM_REQ clients onto one APB port,
// runs SETUP/ACCESS with wait states and a hung-slave timeout.
module apb_rr_master
  import apb_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      Pclk,
  input  logic                      Preset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_slverr,
  apb_rr_master_if.master           apb,
  output state_e                    dbg_state
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  // Handshake: a client command transfers on a rising edge where
  // req_valid[i] & req_ready[i]; req_ready is one-hot and only asserted in a
  // grant window. rsp_valid is a one-cycle pulse with no back-pressure.

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               timeout, done, window;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;

  logic               cmd_write;
  logic [ADDR_W-1:0]  cmd_addr;
  logic [DATA_W-1:0]  cmd_wdata;
  logic [IDX_W-1:0]   cmd_idx;

  logic [ADDR_W-1:0]  addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  wdata_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
    assign wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
  end

  // A ready slave in the last allowed cycle wins over the timeout.
  assign timeout = (state_q == ACCESS) && !apb.Pready && (wait_cnt_q == CNT_W'(TIMEOUT));
  assign done    = (state_q == ACCESS) && (apb.Pready || timeout);
  assign window  = (state_q == IDLE) || done;

  apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk       (Pclk),
    .rst_n     (Preset),
    .req       (req_valid),
    .enable    (window && Preset),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  assign req_ready = grant;

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        state_d    = (|grant) ? SETUP : IDLE;
      end
      SETUP: begin
        wait_cnt_d = CNT_W'(1);
        state_d    = ACCESS;
      end
      ACCESS: begin
        if (done) begin
          wait_cnt_d = '0;
          state_d    = (|grant) ? SETUP : IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: begin
        wait_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      cmd_write <= 1'b0;
      cmd_addr  <= '0;
      cmd_wdata <= '0;
      cmd_idx   <= '0;
    end else if (|grant) begin
      cmd_write <= req_write[grant_idx];
      cmd_addr  <= addr_arr[grant_idx];
      cmd_wdata <= wdata_arr[grant_idx];
      cmd_idx   <= grant_idx;
    end
  end

  always_ff @(posedge Pclk or negedge Preset) begin
    if (!Preset) begin
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_slverr <= 1'b0;
    end else begin
      rsp_valid  <= done ? (NUM_REQ'(1) << cmd_idx) : '0;
      rsp_rdata  <= (done && apb.Pready && !cmd_write) ? apb.Prdata : '0;
      rsp_slverr <= done && (timeout || apb.Pslverr);
    end
  end

  assign apb.Psel    = (state_q != IDLE);
  assign apb.Penable = (state_q == ACCESS);
  assign apb.Pwrite  = cmd_write;
  assign apb.Paddr   = cmd_addr;
  assign apb.Pwdata  = cmd_wdata;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_apb_rr_master.sv
// Directed bench for apb_rr_master: stimulus pushes expected responses,
// a monitor pops and compares on every rsp_valid pulse.
module tb_apb_rr_master;
  import apb_ctrl_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int EXP_W   = NUM_REQ + 1 + DATA_W;

  logic                      Pclk;
  logic                      Preset;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]         rsp_rdata;
  logic                      rsp_slverr;
  state_e                    dbg_state;

  apb_rr_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

  apb_rr_master #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .Pclk       (Pclk),
    .Preset     (Preset),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_slverr (rsp_slverr),
    .apb        (apb),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial Pclk = 1'b0;
  always #5 Pclk = ~Pclk;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [EXP_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge Pclk);
  endtask

  task automatic push_exp(input int client, input logic slverr, input logic [DATA_W-1:0] rdata);
    logic [NUM_REQ-1:0] oh;
    oh = NUM_REQ'(1) << client;
    exp_q.push_back({oh, slverr, rdata});
  endtask

  task automatic set_req(input int c, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_valid[c]                 = 1'b1;
    req_write[c]                 = w;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_wdata[c*DATA_W +: DATA_W] = d;
  endtask

  // scoreboard monitor
  initial begin
    forever begin
      @(negedge Pclk);
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 64'(rsp_valid), 64'd0);
        end else begin
          logic [EXP_W-1:0] e;
          e = exp_q.pop_front();
          check("rsp", 64'({rsp_valid, rsp_slverr, rsp_rdata}), 64'(e));
        end
      end
    end
  end

  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    Preset      = 1'b0;
    req_valid   = '1;
    req_write   = '0;
    req_addr    = '0;
    req_wdata   = '0;
    apb.Prdata  = '0;
    apb.Pready  = 1'b0;
    apb.Pslverr = 1'b0;
    tick();
    tick();

    // reset values, with requests pending to show req_ready gating
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_psel", 64'(apb.Psel), 64'd0);
    check("rst_penable", 64'(apb.Penable), 64'd0);
    check("rst_pwrite", 64'(apb.Pwrite), 64'd0);
    check("rst_paddr", 64'(apb.Paddr), 64'd0);
    check("rst_pwdata", 64'(apb.Pwdata), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    check("rst_rsp_slverr", 64'(rsp_slverr), 64'd0);
    check("rst_state", 64'(dbg_state), 64'(IDLE));
    req_valid = '0;
    Preset    = 1'b1;
    tick();

    // single zero-wait read by client 2
    set_req(2, 1'b0, 32'h0000_0010, 32'h0);
    apb.Pready = 1'b1;
    apb.Prdata = 32'hDEAD_BEEF;
    #1;
    check("rd_grant", 64'(req_ready), 64'h4);
    push_exp(2, 1'b0, 32'hDEAD_BEEF);
    tick();
    req_valid = '0;
    check("rd_setup_psel", 64'(apb.Psel), 64'd1);
    check("rd_setup_penable", 64'(apb.Penable), 64'd0);
    check("rd_setup_paddr", 64'(apb.Paddr), 64'h10);
    check("rd_setup_pwrite", 64'(apb.Pwrite), 64'd0);
    tick();
    check("rd_access_penable", 64'(apb.Penable), 64'd1);
    check("rd_access_paddr", 64'(apb.Paddr), 64'h10);
    tick();
    check("rd_idle_psel", 64'(apb.Psel), 64'd0);
    apb.Pready = 1'b0;

    // write by client 0 with three wait states
    set_req(0, 1'b1, 32'h0000_0020, 32'h1234_5678);
    apb.Prdata = 32'hFFFF_FFFF;
    #1;
    check("wr_grant", 64'(req_ready), 64'h1);
    push_exp(0, 1'b0, 32'h0);
    tick();
    req_valid = '0;
    check("wr_setup_penable", 64'(apb.Penable), 64'd0);
    check("wr_setup_pwrite", 64'(apb.Pwrite), 64'd1);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("wr_penable", 64'(apb.Penable), 64'd1);
      check("wr_pwdata", 64'(apb.Pwdata), 64'h1234_5678);
      apb.Pready = (k == 3);
    end
    tick();
    check("wr_done_penable", 64'(apb.Penable), 64'd0);
    apb.Pready = 1'b0;

    // reset in the middle of a hung access by client 1
    set_req(1, 1'b1, 32'h0000_0030, 32'h0000_CAFE);
    #1;
    check("rstmid_grant", 64'(req_ready), 64'h2);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    check("rstmid_in_access", 64'(dbg_state), 64'(ACCESS));
    req_valid = 4'b1000;
    Preset    = 1'b0;
    #1;
    check("rstmid_req_ready", 64'(req_ready), 64'd0);
    check("rstmid_psel", 64'(apb.Psel), 64'd0);
    check("rstmid_penable", 64'(apb.Penable), 64'd0);
    check("rstmid_pwrite", 64'(apb.Pwrite), 64'd0);
    check("rstmid_paddr", 64'(apb.Paddr), 64'd0);
    check("rstmid_pwdata", 64'(apb.Pwdata), 64'd0);
    check("rstmid_state", 64'(dbg_state), 64'(IDLE));
    tick();
    tick();
    req_valid = '0;
    Preset    = 1'b1;
    tick();
    tick();

    // round-robin fairness: all clients pending, zero-wait slave
    for (int c = 0; c < NUM_REQ; c++) begin
      set_req(c, c[0], 32'h100 + 32'(4 * c), 32'hA000_0000 + 32'(c));
    end
    apb.Pready = 1'b1;
    apb.Prdata = 32'hA5A5_0000;
    for (int k = 0; k < 5; k++) begin
      int g;
      g = order[k];
      #1;
      check("rr_grant", 64'(req_ready), 64'(1 << g));
      if (k > 0) check("rr_psel_access", 64'(apb.Psel), 64'd1);
      push_exp(g, 1'b0, (g % 2 == 1) ? 32'h0 : 32'hA5A5_0000);
      tick();
      check("rr_psel_setup", 64'(apb.Psel), 64'd1);
      check("rr_setup_penable", 64'(apb.Penable), 64'd0);
      check("rr_setup_paddr", 64'(apb.Paddr), 64'(32'h100 + 32'(4 * g)));
      if (k != 0) req_valid[g] = 1'b0;
      tick();
    end
    #1;
    check("rr_tail_ready", 64'(req_ready), 64'd0);
    check("rr_tail_psel", 64'(apb.Psel), 64'd1);
    tick();
    check("rr_end_psel", 64'(apb.Psel), 64'd0);

    // timeout: slave never ready
    apb.Pready = 1'b0;
    apb.Prdata = 32'h5555_5555;
    set_req(1, 1'b0, 32'h0000_0040, 32'h0);
    #1;
    check("to_grant", 64'(req_ready), 64'h2);
    push_exp(1, 1'b1, 32'h0);
    tick();
    req_valid = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      check("to_penable", 64'(apb.Penable), 64'd1);
    end
    tick();
    check("to_idle_state", 64'(dbg_state), 64'(IDLE));
    check("to_idle_psel", 64'(apb.Psel), 64'd0);

    // ready arrives in the last allowed ACCESS cycle: normal completion
    apb.Prdata = 32'h0BAD_F00D;
    set_req(2, 1'b0, 32'h0000_0044, 32'h0);
    #1;
    check("tob_grant", 64'(req_ready), 64'h4);
    push_exp(2, 1'b0, 32'h0BAD_F00D);
    tick();
    req_valid = '0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      tick();
      check("tob_penable", 64'(apb.Penable), 64'd1);
      if (k == TIMEOUT) apb.Pready = 1'b1;
    end
    tick();
    check("tob_idle_state", 64'(dbg_state), 64'(IDLE));

    // slave error on a read by client 3
    apb.Pslverr = 1'b1;
    apb.Prdata  = 32'h0000_0077;
    set_req(3, 1'b0, 32'h0000_0050, 32'h0);
    #1;
    check("err_grant", 64'(req_ready), 64'h8);
    push_exp(3, 1'b1, 32'h0000_0077);
    tick();
    req_valid = '0;
    tick();
    tick();
    apb.Pslverr = 1'b0;

    // pointer wrapped to 0 after client 3
    for (int c = 0; c < NUM_REQ; c++) begin
      set_req(c, 1'b1, 32'h200 + 32'(4 * c), 32'h0);
    end
    #1;
    check("wrap_grant", 64'(req_ready), 64'h1);
    push_exp(0, 1'b0, 32'h0);
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    tick();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
